// File: rtl/mpu_dispatcher.sv
// -----------------------------------------------------------------------------
// mpu_dispatcher
//
// Loads a 3x3 A matrix and a 3x3 B matrix from a register file (raster order,
// one element of each per read strobe), then feeds the systolic/FMA array one
// k-step per FEED cycle: A column k goes out on a_0..a_2, B row k on b_0..b_2.
// Optional idle cycles (STEP_GAP) are inserted between feed steps.
//
// Parameters
//   STEP_GAP  idle cycles between feed steps, legal range 0..7
//   MBITS     register-file address width is MBITS+1 bits (MBITS >= 1)
//
// Ports
//   clk                      rising-edge clock
//   rst                      synchronous active-low reset
//   start_in                 request one load+feed operation (level)
//   collector_busy_in        downstream write-back in progress, blocks start
//   busy_out                 operation in progress (LOAD/FEED/GAP/DONE)
//   dispatcher_finished_out  one-cycle completion pulse
//   reg_read_en_out          register-file read strobe
//   reg_i_out, reg_j_out     read row/column address
//   reg_a_element_in         A read data, valid one cycle after the strobe
//   reg_b_element_in         B read data, valid one cycle after the strobe
//   a_0_out..a_2_out         row operands A[i][k]
//   b_0_out..b_2_out         column operands B[k][j]
//   feed_valid_out           operands valid this cycle
//   feed_last_out            marks the k=2 feed step
//   error_detected_out       one-cycle pulse on a rejected start
//
// Configuration macro
//   MPU_DISPATCH_ERR_EN  when defined, error_detected_out reports starts that
//                        arrive while busy or while the collector is busy;
//                        otherwise it is held at 0.
//
// All outputs are registered: each output flop is loaded from the next-state
// decode, so its value lines up with the state the FSM is in that cycle.
// -----------------------------------------------------------------------------
module mpu_dispatcher #(
    parameter int STEP_GAP = 0,
    parameter int MBITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic             collector_busy_in,
    output logic             busy_out,
    output logic             dispatcher_finished_out,
    output logic             reg_read_en_out,
    output logic [MBITS:0]   reg_i_out,
    output logic [MBITS:0]   reg_j_out,
    input  logic [31:0]      reg_a_element_in,
    input  logic [31:0]      reg_b_element_in,
    output logic [31:0]      a_0_out,
    output logic [31:0]      a_1_out,
    output logic [31:0]      a_2_out,
    output logic [31:0]      b_0_out,
    output logic [31:0]      b_1_out,
    output logic [31:0]      b_2_out,
    output logic             feed_valid_out,
    output logic             feed_last_out,
    output logic             error_detected_out
);

    localparam int           IDX_W    = MBITS + 1;
    localparam bit           GAP_EN   = (STEP_GAP > 0);
    localparam logic [2:0]   GAP_LAST = (STEP_GAP > 0) ? 3'(STEP_GAP - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FEED = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   load_cnt_q, load_cnt_d;
    logic [1:0]   step_q, step_d;
    logic [2:0]   gap_q, gap_d;

    // Operand buffers, element e = row*3 + col
    logic [31:0]  a_buf_q [0:8];
    logic [31:0]  b_buf_q [0:8];

    logic         busy_q, busy_d;
    logic         finished_q, finished_d;
    logic         rd_en_q, rd_en_d;
    logic [MBITS:0] reg_i_q, reg_i_d;
    logic [MBITS:0] reg_j_q, reg_j_d;
    logic [31:0]  a0_q, a0_d, a1_q, a1_d, a2_q, a2_d;
    logic [31:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic         feed_valid_q, feed_valid_d;
    logic         feed_last_q, feed_last_d;
    logic         err_q, err_d;
    logic [3:0]   kx3_s;

    // Row of raster element c (i-major order)
    function automatic logic [1:0] raster_row(input logic [3:0] c);
        logic [1:0] r;
        case (c)
            4'd0, 4'd1, 4'd2: r = 2'd0;
            4'd3, 4'd4, 4'd5: r = 2'd1;
            4'd6, 4'd7, 4'd8: r = 2'd2;
            default:          r = 2'd0;
        endcase
        return r;
    endfunction

    // Column of raster element c (i-major order)
    function automatic logic [1:0] raster_col(input logic [3:0] c);
        logic [1:0] r;
        case (c)
            4'd0, 4'd3, 4'd6: r = 2'd0;
            4'd1, 4'd4, 4'd7: r = 2'd1;
            4'd2, 4'd5, 4'd8: r = 2'd2;
            default:          r = 2'd0;
        endcase
        return r;
    endfunction

    // Next-state and counter logic
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        step_d     = step_q;
        gap_d      = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in && !collector_busy_in) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = 4'd0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_cnt_q == 4'd9) begin
                    state_d    = ST_FEED;
                    load_cnt_d = 4'd0;
                    step_d     = 2'd0;
                end else begin
                    load_cnt_d = load_cnt_q + 4'd1;
                end
            end
            ST_FEED: begin
                // The last step never gets a trailing gap
                if (step_q == 2'd2) begin
                    state_d = ST_DONE;
                    step_d  = 2'd0;
                end else if (GAP_EN) begin
                    state_d = ST_GAP;
                    gap_d   = 3'd0;
                end else begin
                    step_d  = step_q + 2'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_FEED;
                    gap_d   = 3'd0;
                    step_d  = step_q + 2'd1;
                end else begin
                    gap_d   = gap_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                load_cnt_d = 4'd0;
                step_d     = 2'd0;
                gap_d      = 3'd0;
            end
        endcase
    end

    // Output decode from the next state, loaded into the output flops
    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        finished_d   = (state_d == ST_DONE);
        rd_en_d      = (state_d == ST_LOAD) && (load_cnt_d <= 4'd8);
        feed_valid_d = (state_d == ST_FEED);
        feed_last_d  = (state_d == ST_FEED) && (step_d == 2'd2);
        kx3_s        = ({2'b00, step_d} << 1) + {2'b00, step_d};
        if (rd_en_d) begin
            reg_i_d = IDX_W'(raster_row(load_cnt_d));
            reg_j_d = IDX_W'(raster_col(load_cnt_d));
        end else begin
            reg_i_d = '0;
            reg_j_d = '0;
        end
        if (state_d == ST_FEED) begin
            a0_d = a_buf_q[{2'b00, step_d}];
            a1_d = a_buf_q[4'd3 + {2'b00, step_d}];
            a2_d = a_buf_q[4'd6 + {2'b00, step_d}];
            b0_d = b_buf_q[kx3_s];
            b1_d = b_buf_q[kx3_s + 4'd1];
            b2_d = b_buf_q[kx3_s + 4'd2];
        end else begin
            a0_d = 32'd0;
            a1_d = 32'd0;
            a2_d = 32'd0;
            b0_d = 32'd0;
            b1_d = 32'd0;
            b2_d = 32'd0;
        end
`ifdef MPU_DISPATCH_ERR_EN
        // Rejected start: busy, or idle with the collector still writing back
        err_d = start_in && ((state_q != ST_IDLE) || collector_busy_in);
`else
        err_d = 1'b0;
`endif
    end

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            load_cnt_q   <= 4'd0;
            step_q       <= 2'd0;
            gap_q        <= 3'd0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            reg_i_q      <= '0;
            reg_j_q      <= '0;
            a0_q         <= 32'd0;
            a1_q         <= 32'd0;
            a2_q         <= 32'd0;
            b0_q         <= 32'd0;
            b1_q         <= 32'd0;
            b2_q         <= 32'd0;
            feed_valid_q <= 1'b0;
            feed_last_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            step_q       <= step_d;
            gap_q        <= gap_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            rd_en_q      <= rd_en_d;
            reg_i_q      <= reg_i_d;
            reg_j_q      <= reg_j_d;
            a0_q         <= a0_d;
            a1_q         <= a1_d;
            a2_q         <= a2_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            b2_q         <= b2_d;
            feed_valid_q <= feed_valid_d;
            feed_last_q  <= feed_last_d;
            err_q        <= err_d;
        end
    end

    // Operand capture: data read by strobe c-1 is present while the counter is c
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int e = 0; e < 9; e++) begin
                a_buf_q[e] <= 32'd0;
                b_buf_q[e] <= 32'd0;
            end
        end else if ((state_q == ST_LOAD) && (load_cnt_q != 4'd0)) begin
            a_buf_q[load_cnt_q - 4'd1] <= reg_a_element_in;
            b_buf_q[load_cnt_q - 4'd1] <= reg_b_element_in;
        end else begin
            for (int e = 0; e < 9; e++) begin
                a_buf_q[e] <= a_buf_q[e];
                b_buf_q[e] <= b_buf_q[e];
            end
        end
    end

    assign busy_out                = busy_q;
    assign dispatcher_finished_out = finished_q;
    assign reg_read_en_out         = rd_en_q;
    assign reg_i_out               = reg_i_q;
    assign reg_j_out               = reg_j_q;
    assign a_0_out                 = a0_q;
    assign a_1_out                 = a1_q;
    assign a_2_out                 = a2_q;
    assign b_0_out                 = b0_q;
    assign b_1_out                 = b1_q;
    assign b_2_out                 = b2_q;
    assign feed_valid_out          = feed_valid_q;
    assign feed_last_out           = feed_last_q;
    assign error_detected_out      = err_q;

endmodule

// File: tb/tb_mpu_dispatcher.sv
// Two dispatchers (STEP_GAP=0 and STEP_GAP=2) share start/collector/reset
// stimulus; each has its own register-file responder. A timeline model derived
// from the operation's cycle offsets predicts every output in every cycle.
module tb_mpu_dispatcher;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic cbusy = 1'b0;

    logic        busy0, fin0, rd0, fv0, fl0, err0;
    logic [1:0]  ri0, rj0;
    logic [31:0] ad0, bd0, a00, a01, a02, b00, b01, b02;
    logic        busy1, fin1, rd1, fv1, fl1, err1;
    logic [1:0]  ri1, rj1;
    logic [31:0] ad1, bd1, a10, a11, a12, b10, b11, b12;

    logic [31:0] mem_a [3][3];
    logic [31:0] mem_b [3][3];

    int checks = 0;
    int errors = 0;

    // Timeline model state
    int          edge_n = 0;
    int          act [2];
    int          tst [2];
    int          gap [2];
    logic        err_exp [2];
    logic [31:0] snap_a [2][3][3];
    logic [31:0] snap_b [2][3][3];

    always #5 clk = ~clk;

    mpu_dispatcher #(.STEP_GAP(0), .MBITS(1)) u_g0 (
        .clk(clk), .rst(rst), .start_in(start), .collector_busy_in(cbusy),
        .busy_out(busy0), .dispatcher_finished_out(fin0), .reg_read_en_out(rd0),
        .reg_i_out(ri0), .reg_j_out(rj0),
        .reg_a_element_in(ad0), .reg_b_element_in(bd0),
        .a_0_out(a00), .a_1_out(a01), .a_2_out(a02),
        .b_0_out(b00), .b_1_out(b01), .b_2_out(b02),
        .feed_valid_out(fv0), .feed_last_out(fl0), .error_detected_out(err0)
    );

    mpu_dispatcher #(.STEP_GAP(2), .MBITS(1)) u_g2 (
        .clk(clk), .rst(rst), .start_in(start), .collector_busy_in(cbusy),
        .busy_out(busy1), .dispatcher_finished_out(fin1), .reg_read_en_out(rd1),
        .reg_i_out(ri1), .reg_j_out(rj1),
        .reg_a_element_in(ad1), .reg_b_element_in(bd1),
        .a_0_out(a10), .a_1_out(a11), .a_2_out(a12),
        .b_0_out(b10), .b_1_out(b11), .b_2_out(b12),
        .feed_valid_out(fv1), .feed_last_out(fl1), .error_detected_out(err1)
    );

    // Register file for u_g0: data valid the cycle after the strobe, junk otherwise
    always begin : resp0
        logic en;
        logic [1:0] ii, jj;
        @(negedge clk);
        en = rd0; ii = ri0; jj = rj0;
        @(posedge clk);
        #1;
        if (en === 1'b1 && ii < 2'd3 && jj < 2'd3) begin
            ad0 = mem_a[ii][jj];
            bd0 = mem_b[ii][jj];
        end else begin
            ad0 = $urandom;
            bd0 = $urandom;
        end
    end

    // Register file for u_g2
    always begin : resp1
        logic en;
        logic [1:0] ii, jj;
        @(negedge clk);
        en = rd1; ii = ri1; jj = rj1;
        @(posedge clk);
        #1;
        if (en === 1'b1 && ii < 2'd3 && jj < 2'd3) begin
            ad1 = mem_a[ii][jj];
            bd1 = mem_b[ii][jj];
        end else begin
            ad1 = $urandom;
            bd1 = $urandom;
        end
    end

    function automatic int op_len(int u);
        return 14 + 2 * gap[u];
    endfunction

    // Busy during the cycle that ends at edge e
    function automatic bit m_busy(int u, int e);
        return (act[u] != 0) && (e - tst[u] >= 1) && (e - tst[u] <= op_len(u));
    endfunction

    // Model update at each clock edge from the inputs sampled there
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        for (int u = 0; u < 2; u++) begin
            if (!rst) begin
                act[u]     = 0;
                err_exp[u] = 1'b0;
            end else begin
`ifdef MPU_DISPATCH_ERR_EN
                err_exp[u] = start && (m_busy(u, edge_n) || cbusy);
`else
                err_exp[u] = 1'b0;
`endif
                if (start && !cbusy && !m_busy(u, edge_n)) begin
                    act[u] = 1;
                    tst[u] = edge_n;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++) begin
                            snap_a[u][i][j] = mem_a[i][j];
                            snap_b[u][i][j] = mem_b[i][j];
                        end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input int u,
                             input logic busy, input logic fin, input logic rd,
                             input logic [1:0] ri, input logic [1:0] rj,
                             input logic fv, input logic fl, input logic err,
                             input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                             input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
        int d, k;
        logic e_busy, e_fin, e_rd, e_fv, e_fl;
        logic [1:0] e_ri, e_rj;
        logic [31:0] e_a [3];
        logic [31:0] e_b [3];
        string p;
        p = (u == 0) ? "g0" : "g2";
        d = (act[u] != 0) ? (edge_n + 1 - tst[u]) : -1000;
        e_busy = (d >= 1) && (d <= op_len(u));
        e_fin  = (d == op_len(u));
        e_rd   = (d >= 1) && (d <= 9);
        e_ri   = e_rd ? 2'((d - 1) / 3) : 2'd0;
        e_rj   = e_rd ? 2'((d - 1) % 3) : 2'd0;
        k = -1;
        for (int s = 0; s < 3; s++)
            if (d == 11 + s * (gap[u] + 1)) k = s;
        e_fv = (k >= 0);
        e_fl = (k == 2);
        for (int i = 0; i < 3; i++) begin
            e_a[i] = (k >= 0) ? snap_a[u][i][k] : 32'd0;
            e_b[i] = (k >= 0) ? snap_b[u][k][i] : 32'd0;
        end
        chk({p, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({p, ".finished"}, {31'd0, fin}, {31'd0, e_fin});
        chk({p, ".rd_en"}, {31'd0, rd}, {31'd0, e_rd});
        chk({p, ".reg_i"}, {30'd0, ri}, {30'd0, e_ri});
        chk({p, ".reg_j"}, {30'd0, rj}, {30'd0, e_rj});
        chk({p, ".feed_valid"}, {31'd0, fv}, {31'd0, e_fv});
        chk({p, ".feed_last"}, {31'd0, fl}, {31'd0, e_fl});
        chk({p, ".error"}, {31'd0, err}, {31'd0, err_exp[u]});
        chk({p, ".a_0"}, a0, e_a[0]);
        chk({p, ".a_1"}, a1, e_a[1]);
        chk({p, ".a_2"}, a2, e_a[2]);
        chk({p, ".b_0"}, b0, e_b[0]);
        chk({p, ".b_1"}, b1, e_b[1]);
        chk({p, ".b_2"}, b2, e_b[2]);
    endtask

    // Compare both DUTs against the model mid-cycle
    always @(negedge clk) begin
        if (edge_n >= 1) begin
            check_dut(0, busy0, fin0, rd0, ri0, rj0, fv0, fl0, err0, a00, a01, a02, b00, b01, b02);
            check_dut(1, busy1, fin1, rd1, ri1, rj1, fv1, fl1, err1, a10, a11, a12, b10, b11, b12);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                mem_a[i][j] = $urandom;
                mem_b[i][j] = $urandom;
            end
    endtask

    initial begin
        gap[0] = 0;
        gap[1] = 2;
        act[0] = 0;
        act[1] = 0;
        tst[0] = 0;
        tst[1] = 0;
        err_exp[0] = 1'b0;
        err_exp[1] = 1'b0;
        ad0 = 32'd0; bd0 = 32'd0; ad1 = 32'd0; bd1 = 32'd0;

        // Tag data: A[i][j] = 0x0A00 + {i,j}, B[i][j] = 0x0B00 + {i,j}
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                mem_a[i][j] = 32'h0000_0A00 + 32'(i * 16 + j);
                mem_b[i][j] = 32'h0000_0B00 + 32'(i * 16 + j);
            end

        // Reset state
        cyc(3);
        rst = 1'b1;
        cyc(2);

        // Tag load with both gap settings
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(22);

        // Start pulsed again during LOAD
        rand_mem();
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(22);

        // Start held while the collector is busy, then released
        rand_mem();
        cbusy = 1'b1; start = 1'b1;
        cyc(4);
        cbusy = 1'b0;
        cyc(1);
        start = 1'b0;
        cyc(22);

        // Reset in the middle of FEED, then a fresh start
        rand_mem();
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(11);
        rst = 1'b0; cyc(1); rst = 1'b1;
        cyc(1);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(22);

        // Start held high: back-to-back operations
        rand_mem();
        start = 1'b1; cyc(40); start = 1'b0;
        cyc(22);

        // Randomized start / collector / reset traffic
        repeat (8) begin
            rand_mem();
            repeat (60) begin
                start = ($urandom_range(0, 3) == 0);
                cbusy = ($urandom_range(0, 3) == 0);
                rst   = ($urandom_range(0, 49) != 0);
                cyc(1);
            end
            start = 1'b0;
            cbusy = 1'b0;
            rst   = 1'b1;
            cyc(25);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpu_dispatcher.md
MPU_DISPATCHER -- requirements
Module: mpu_dispatcher

Interface
REQ-001 STEP_GAP, default 0, idle cycles inserted after each feed step (0..7); values above 7 are illegal.
REQ-002 clk  in  1  clock; all logic on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-low.
REQ-004 start_in  in  1  begin one 3x3 load+feed operation; level sampled each cycle.
REQ-005 collector_busy_in  in  1  downstream collector writing back; blocks start.
REQ-006 busy_out  out  1  operation in progress.
REQ-007 dispatcher_finished_out  out  1  one-cycle pulse, operation complete.
REQ-008 reg_read_en_out  out  1  register-file read strobe.
REQ-009 reg_i_out, reg_j_out  out  MBITS+1 each  read row/column address, shared by both matrices.
REQ-010 reg_a_element_in, reg_b_element_in  in  32 (float_sp) each  read data, valid exactly 1 cycle after strobe.
REQ-011 a_0_out, a_1_out, a_2_out  out  32 (float_sp) each  row operands A[i][k] for i=0..2.
REQ-012 b_0_out, b_1_out, b_2_out  out  32 (float_sp) each  column operands B[k][j] for j=0..2.
REQ-013 feed_valid_out  out  1  operands valid this cycle.
REQ-014 feed_last_out  out  1  marks step k=2; FMA units raise ready after it.
REQ-015 error_detected_out  out  1  one-cycle error pulse.

Function
REQ-016 States: IDLE, LOAD, FEED, GAP, DONE; no other encodings are reachable.
REQ-017 IDLE->LOAD at the edge where start_in=1 and collector_busy_in=0; start_in with collector_busy_in=1 is ignored.
REQ-018 LOAD is 10 cycles, load counter c=0..9; reg_read_en_out=1 for c=0..8 only.
REQ-019 LOAD addresses: raster order, i-major; reg_i_out=c/3, reg_j_out=c%3; both are 0 when strobe is low.
REQ-020 Capture: at c=1..9, reg_a_element_in->a_buf[(c-1)/3][(c-1)%3]; reg_b_element_in->b_buf likewise.
REQ-021 LOAD->FEED after c=9; step counter k is 0 on entry.
REQ-022 FEED lasts 1 cycle per step: feed_valid_out=1, a_i_out=a_buf[i][k], b_j_out=b_buf[k][j]; feed_last_out=(k==2).
REQ-023 After FEED with STEP_GAP>0: go to GAP for exactly STEP_GAP cycles, then k+1 and back to FEED; the k=2 step goes directly to DONE, with no trailing gap.
REQ-024 After FEED with STEP_GAP=0: k+1 and FEED again, or DONE after k=2.
REQ-025 Outside FEED: all a_*/b_* outputs are 0; feed_valid_out and feed_last_out are 0.
REQ-026 DONE lasts 1 cycle: dispatcher_finished_out=1; next state is IDLE.
REQ-027 busy_out=1 in LOAD, FEED, GAP and DONE.
REQ-028 Latency with STEP_GAP=0, start sampled at edge T:
  - LOAD occupies cycles T+1..T+10.
  - FEED occupies T+11..T+13.
  - DONE at T+14.
  - IDLE at T+15; a new start is accepted at edge T+15.
REQ-029 General total: 14+2*STEP_GAP cycles from start edge to the finished pulse, inclusive of DONE.
REQ-030 start_in while busy_out=1 is ignored and does not disturb the operation.
REQ-031 a_buf/b_buf are retained in IDLE; they are overwritten only by the next LOAD.

Reset
REQ-032 With rst=0 at an edge, the following take effect that edge and apply from the next cycle:
  - state=IDLE; c, k and the gap counter =0.
  - a_buf and b_buf all zero.
  - every output 0.
REQ-033 Reset mid-operation aborts it: no finished pulse, no further feed_valid_out; reset wins over a simultaneous start_in.

Configuration
REQ-034 Macro MPU_DISPATCH_ERR_EN defined: error_detected_out pulses 1 cycle, registered, on either condition:
  - start_in=1 while busy_out=1;
  - start_in=1 in IDLE while collector_busy_in=1.
REQ-035 Macro MPU_DISPATCH_ERR_EN undefined: error_detected_out is constant 0; rejected starts are silently ignored; all other behaviour is identical.

Verification
REQ-036 Tag load, STEP_GAP=0: A[i][j]=32'h0000_0A00+{i,j}, B=32'h0000_0B00+{i,j}; start at T -> strobes T+1..T+9 with addresses (0,0)..(2,2); at T+12 a_1_out=32'h0A11, b_2_out=32'h0B12; feed_last_out only at T+13; finished at T+14.
REQ-037 STEP_GAP=2, same data -> feed_valid_out at T+11, T+14, T+17; finished at T+18; operand outputs are 0 in gap cycles.
REQ-038 Start pulsed at T+5 during LOAD (ERR_EN defined) -> error_detected_out=1 at T+6 only; sequence timing unchanged.
REQ-039 start_in=1 with collector_busy_in=1 for 4 cycles, then collector_busy_in drops -> no strobe while blocked; LOAD begins the cycle after the first edge with collector_busy_in=0.
REQ-040 rst=0 at T+12 -> from T+13 all outputs are 0, no finished pulse; a fresh start at T+14 runs a full sequence reading (0,0) first.
